// File: rtl/eth_mdio_c45.sv
`default_nettype none
// ============================================================================
// Module      : eth_mdio_c45
// Description : MDIO management master for Clause 22 and Clause 45 frames
//               (address / write / read / read-increment). MDC is derived
//               from clk by G_DIV; preamble length is G_PRE_LEN bits. A read
//               whose second turnaround bit is not 0 reports usr_err.
//               Optional: define ETH_MDIO_PRE_SUPPRESS_EN to add the
//               usr_nopre input (skip the preamble per request).
// Revision    : 1.0 - initial release
// ============================================================================
module eth_mdio_c45 #(
    parameter int G_DIV     = 2,
    parameter int G_PRE_LEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        usr_start,
    input  logic        usr_c45,
    input  logic [1:0]  usr_op,
    input  logic [4:0]  usr_aphy,
    input  logic [4:0]  usr_areg,
`ifdef ETH_MDIO_PRE_SUPPRESS_EN
    input  logic        usr_nopre,
`endif
    input  logic [15:0] usr_txd,
    output logic [15:0] usr_rxd,
    output logic        usr_done,
    output logic        usr_busy,
    output logic        usr_err,
    output logic        p_out_mdio_t,
    output logic        p_out_mdio,
    input  logic        p_in_mdio,
    output logic        p_out_mdc
);

    localparam int                 c_div_w    = $clog2(2 * G_DIV);
    localparam logic [c_div_w-1:0] c_div_mid  = c_div_w'(G_DIV);
    localparam logic [c_div_w-1:0] c_div_cmt  = c_div_w'(2 * G_DIV - 2);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(2 * G_DIV - 1);
    localparam logic [4:0]         c_pre_cnt  = (G_PRE_LEN == 0) ? 5'd0 : 5'(G_PRE_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_HDR  = 3'd2,
        S_TA   = 3'd3,
        S_DATA = 3'd4,
        S_END  = 3'd5,
        S_INV  = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [4:0]          r_bit;
    logic [4:0]          w_bit_nxt;
    logic [c_div_w-1:0]  r_div;
    logic                r_start_d;
    logic [31:0]         r_frame;
    logic                r_rd;
    logic [15:0]         r_rx;
    logic                r_ta_err;
    logic [15:0]         r_rxd;
    logic                r_err;

    logic                w_active;
    logic                w_bit_end;
    logic                w_accept;
    logic                w_inv;
    logic                w_pre_en;

    assign w_active  = (r_state == S_PRE) || (r_state == S_HDR) || (r_state == S_TA) ||
                       (r_state == S_DATA) || (r_state == S_END);
    assign w_bit_end = w_active && (r_div == c_div_last);
    assign w_accept  = (r_state == S_IDLE) && usr_start && !r_start_d;
    // Clause 22 has no meaning for opcodes 00 and 11
    assign w_inv     = !usr_c45 && (usr_op[1] == usr_op[0]);
`ifdef ETH_MDIO_PRE_SUPPRESS_EN
    assign w_pre_en  = (G_PRE_LEN != 0) && !usr_nopre;
`else
    assign w_pre_en  = (G_PRE_LEN != 0);
`endif

    assign usr_rxd = r_rxd;
    assign usr_err = r_err;

    // State, bit counter and MDC phase counter; phase counter idles at 0 so MDC starts low
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_bit   <= 5'd0;
            r_div   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bit   <= w_bit_nxt;
            if (w_active) begin
                r_div <= w_bit_end ? '0 : r_div + c_div_w'(1);
            end else begin
                r_div <= '0;
            end
        end
    end

    // Next state and pad/handshake outputs; outputs decode registered state only
    always_comb begin
        w_state_nxt  = r_state;
        w_bit_nxt    = r_bit;
        usr_busy     = (r_state != S_IDLE);
        usr_done     = 1'b0;
        p_out_mdc    = w_active && (r_div >= c_div_mid);
        p_out_mdio   = 1'b1;
        p_out_mdio_t = 1'b1;
        if (w_bit_end && (r_bit != 5'd0)) begin
            w_bit_nxt = r_bit - 5'd1;
        end
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_inv) begin
                        w_state_nxt = S_INV;
                    end else if (w_pre_en) begin
                        w_state_nxt = S_PRE;
                        w_bit_nxt   = c_pre_cnt;
                    end else begin
                        w_state_nxt = S_HDR;
                        w_bit_nxt   = 5'd13;
                    end
                end
            end
            S_INV: begin
                usr_done    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_PRE: begin
                p_out_mdio_t = 1'b0;
                if (w_bit_end && (r_bit == 5'd0)) begin
                    w_state_nxt = S_HDR;
                    w_bit_nxt   = 5'd13;
                end
            end
            S_HDR: begin
                p_out_mdio_t = 1'b0;
                p_out_mdio   = r_frame[31];
                if (w_bit_end && (r_bit == 5'd0)) begin
                    w_state_nxt = S_TA;
                    w_bit_nxt   = 5'd1;
                end
            end
            S_TA: begin
                p_out_mdio_t = r_rd;
                p_out_mdio   = r_rd | r_frame[31];
                if (w_bit_end && (r_bit == 5'd0)) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = 5'd15;
                end
            end
            S_DATA: begin
                p_out_mdio_t = r_rd;
                p_out_mdio   = r_rd | r_frame[31];
                if (w_bit_end && (r_bit == 5'd0)) begin
                    w_state_nxt = S_END;
                    w_bit_nxt   = 5'd0;
                end
            end
            S_END: begin
                if (w_bit_end) begin
                    usr_done    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request latch, frame shifter, read sampling and end-of-op status commit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_d <= 1'b0;
            r_frame   <= 32'd0;
            r_rd      <= 1'b0;
            r_rx      <= 16'd0;
            r_ta_err  <= 1'b0;
            r_rxd     <= 16'd0;
            r_err     <= 1'b0;
        end else begin
            r_start_d <= usr_start;
            if (w_accept) begin
                r_frame <= {(usr_c45 ? 2'b00 : 2'b01), usr_op, usr_aphy, usr_areg, 2'b10, usr_txd};
                r_rd    <= usr_op[1];
                r_err   <= w_inv;
            end else if (w_bit_end && ((r_state == S_HDR) || (r_state == S_TA) || (r_state == S_DATA))) begin
                r_frame <= {r_frame[30:0], 1'b0};
            end
            // Sample in the cycle MDC rises
            if (w_active && (r_div == c_div_mid)) begin
                if ((r_state == S_TA) && (r_bit == 5'd0)) begin
                    r_ta_err <= p_in_mdio;
                end
                if (r_state == S_DATA) begin
                    r_rx <= {r_rx[14:0], p_in_mdio};
                end
            end
            // Commit so status is visible in the usr_done cycle
            if ((r_state == S_END) && (r_div == c_div_cmt)) begin
                if (r_rd) begin
                    r_rxd <= r_rx;
                    r_err <= r_ta_err;
                end else begin
                    r_err <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_mdio_c45.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_mdio_c45
// Description : Directed self-checking bench for eth_mdio_c45 (G_DIV=2,
//               G_PRE_LEN=32) with a bit-level wire monitor and PHY model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_mdio_c45;

    logic        clk = 1'b0;
    logic        rst;
    logic        usr_start;
    logic        usr_c45;
    logic [1:0]  usr_op;
    logic [4:0]  usr_aphy;
    logic [4:0]  usr_areg;
    logic [15:0] usr_txd;
    logic [15:0] usr_rxd;
    logic        usr_done;
    logic        usr_busy;
    logic        usr_err;
    logic        p_out_mdio_t;
    logic        p_out_mdio;
    logic        p_in_mdio;
    logic        p_out_mdc;
`ifdef ETH_MDIO_PRE_SUPPRESS_EN
    logic        usr_nopre = 1'b0;
`endif

    int n_chk = 0;
    int n_bad = 0;

    eth_mdio_c45 #(.G_DIV(2), .G_PRE_LEN(32)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .usr_start    (usr_start),
        .usr_c45      (usr_c45),
        .usr_op       (usr_op),
        .usr_aphy     (usr_aphy),
        .usr_areg     (usr_areg),
`ifdef ETH_MDIO_PRE_SUPPRESS_EN
        .usr_nopre    (usr_nopre),
`endif
        .usr_txd      (usr_txd),
        .usr_rxd      (usr_rxd),
        .usr_done     (usr_done),
        .usr_busy     (usr_busy),
        .usr_err      (usr_err),
        .p_out_mdio_t (p_out_mdio_t),
        .p_out_mdio   (p_out_mdio),
        .p_in_mdio    (p_in_mdio),
        .p_out_mdc    (p_out_mdc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one request and monitor it bit by bit; hdr = ST,OP,PHY,REG,TA(10)
    task automatic run_frame(input string tag, input logic c45, input logic [1:0] op,
                             input logic [4:0] aphy, input logic [4:0] areg,
                             input logic [15:0] txd, input logic [15:0] hdr,
                             input logic phy_ta, input logic [15:0] phy_data,
                             input logic [15:0] exp_rxd, input logic exp_err);
        logic [64:0] wb, tb_bits, exp_w, mask, exp_t;
        logic [15:0] rxd_at_done;
        logic        err_at_done;
        int i, b, ph, done_at, n_done, bad_mdc, bad_stab;
        wb = '0; tb_bits = '0; rxd_at_done = '0; err_at_done = 1'b0;
        done_at = -1; n_done = 0; bad_mdc = 0; bad_stab = 0; i = 0;
        @(posedge clk); #1;
        usr_c45 = c45; usr_op = op; usr_aphy = aphy; usr_areg = areg; usr_txd = txd;
        usr_start = 1'b1;
        @(posedge clk); #1;
        usr_start = 1'b0;
        while (i < 2000) begin
            @(negedge clk);
            if (!usr_busy) break;
            b  = i / 4;
            ph = i % 4;
            if (b <= 64) begin
                if (ph == 0) begin
                    wb[64-b]      = p_out_mdio;
                    tb_bits[64-b] = p_out_mdio_t;
                    p_in_mdio = (b == 47) ? phy_ta :
                                ((b >= 48) && (b < 64)) ? phy_data[63-b] : 1'b1;
                end else if ((p_out_mdio_t !== tb_bits[64-b]) ||
                             (!p_out_mdio_t && (p_out_mdio !== wb[64-b]))) begin
                    bad_stab++;
                end
            end
            if (p_out_mdc !== (ph >= 2)) bad_mdc++;
            if (usr_done) begin
                n_done++;
                done_at     = i;
                rxd_at_done = usr_rxd;
                err_at_done = usr_err;
            end
            i++;
        end
        p_in_mdio = 1'b1;
        exp_w = {32'hFFFF_FFFF, hdr, txd, 1'b1};
        mask  = op[1] ? {{46{1'b1}}, {19{1'b0}}} : {65{1'b1}};
        exp_t = op[1] ? {46'd0, {19{1'b1}}} : {64'd0, 1'b1};
        check({tag, ".busy_len"}, 80'(i), 80'd260);
        check({tag, ".done_cnt"}, 80'(n_done), 80'd1);
        check({tag, ".done_at"},  80'(done_at), 80'd259);
        check({tag, ".mdc"},      80'(bad_mdc), 80'd0);
        check({tag, ".stable"},   80'(bad_stab), 80'd0);
        check({tag, ".wire"},     80'(wb & mask), 80'(exp_w & mask));
        check({tag, ".mdio_t"},   80'(tb_bits), 80'(exp_t));
        check({tag, ".rxd"},      80'(rxd_at_done), 80'(exp_rxd));
        check({tag, ".err"},      80'(err_at_done), 80'(exp_err));
    endtask

    initial begin
        int nd, nb;
        rst = 1'b1; usr_start = 1'b0; usr_c45 = 1'b0; usr_op = 2'b00;
        usr_aphy = 5'd0; usr_areg = 5'd0; usr_txd = 16'd0; p_in_mdio = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset", {usr_busy, usr_done, usr_err, p_out_mdio_t, p_out_mdio, p_out_mdc, usr_rxd},
              {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000});
        @(posedge clk); #1 rst = 1'b0;

        // 1: C22 write, header 01 01 00110 01011 10
        run_frame("c22_wr", 1'b0, 2'b01, 5'h06, 5'h0B, 16'h8FFA, 16'h532E, 1'b1, 16'hFFFF, 16'h0000, 1'b0);
        // 2: C22 read, PHY answers 0x1234
        run_frame("c22_rd", 1'b0, 2'b10, 5'h01, 5'h02, 16'h0000, 16'h608A, 1'b0, 16'h1234, 16'h1234, 1'b0);
        // 3: C22 read, no PHY
        run_frame("c22_nophy", 1'b0, 2'b10, 5'h01, 5'h02, 16'h0000, 16'h608A, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        // 4: C45 address then read-increment
        run_frame("c45_addr", 1'b1, 2'b00, 5'h03, 5'h01, 16'h0100, 16'h0186, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
        run_frame("c45_rdinc", 1'b1, 2'b10, 5'h03, 5'h01, 16'h0000, 16'h2186, 1'b0, 16'hBEEF, 16'hBEEF, 1'b0);

        // 5a: start held high for 1000 clocks -> one frame only
        @(posedge clk); #1;
        usr_c45 = 1'b0; usr_op = 2'b01; usr_aphy = 5'h06; usr_areg = 5'h0B; usr_txd = 16'h1111;
        usr_start = 1'b1;
        nd = 0; nb = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (usr_done) nd++;
            if (usr_busy) nb++;
        end
        check("hold.done_cnt", 80'(nd), 80'd1);
        check("hold.busy_cnt", 80'(nb), 80'd260);
        @(posedge clk); #1 usr_start = 1'b0;

        // 5b: C22 opcode 00 is rejected immediately
        @(posedge clk); #1;
        usr_op = 2'b00; usr_start = 1'b1;
        @(posedge clk); #1 usr_start = 1'b0;
        @(negedge clk);
        check("inv.first", {usr_busy, usr_done, usr_err, p_out_mdc, p_out_mdio_t}, {1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
        @(negedge clk);
        check("inv.after", {usr_busy, usr_done, usr_err, p_out_mdc}, {1'b0, 1'b0, 1'b1, 1'b0});

        // 6: reset during data phase, then a clean write
        @(posedge clk); #1;
        usr_op = 2'b01; usr_txd = 16'hA5A5; usr_start = 1'b1;
        @(posedge clk); #1 usr_start = 1'b0;
        repeat (220) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort.outs", {usr_busy, usr_done, usr_err, p_out_mdio_t, p_out_mdio, p_out_mdc, usr_rxd},
              {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000});
        @(posedge clk); #1 rst = 1'b0;
        nd = 0; nb = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (usr_done) nd++;
            if (usr_busy || p_out_mdc) nb++;
        end
        check("abort.quiet", 80'({nd, nb}), 80'd0);
        run_frame("post_abort", 1'b0, 2'b01, 5'h06, 5'h0B, 16'h8FFA, 16'h532E, 1'b1, 16'hFFFF, 16'h0000, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
